// File: rtl/tone_sequencer.sv
// tone_sequencer: plays a table of (divider, duration) steps as timed tones with optional
// silent gaps, end-of-sequence marker, looping and abort.
`default_nettype none

module tone_sequencer #(
   parameter int TICK_DIV  = 100000,
   parameter int GAP_TICKS = 2,
   parameter int ADDR_W    = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              loop,
   output logic [ADDR_W-1:0] step_addr,
   input  logic [15:0]       step_data,
   output logic [9:0]        div,
   output logic              en,
   output logic              busy,
   output logic              done
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_PLAY  = 3'd2;
   localparam logic [2:0] S_GAP   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam int               PW         = $clog2(TICK_DIV);
   localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [5:0]       GAP_CNT    = 6'(GAP_TICKS);
   localparam logic [ADDR_W-1:0] IDX_LAST  = '1;
   localparam bit               HAS_GAP    = (GAP_TICKS > 0);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [9:0]        div_q, div_d;
   logic [PW-1:0]     presc_q, presc_d;
   logic [5:0]        cnt_q, cnt_d;
   logic              en_q, busy_q, done_q;

   logic              tick;
   logic              last_tick;
   logic              seq_end;
   logic [5:0]        fetch_dur;

   assign tick      = (presc_q == PRESC_LAST);
   assign last_tick = tick && (cnt_q == 6'd1);
   assign seq_end   = (idx_q == IDX_LAST);
   assign fetch_dur = step_data[15:10];

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      div_d   = div_q;
      presc_d = presc_q;
      cnt_d   = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (start && !stop) begin
               state_d = S_FETCH;
               idx_d   = '0;
            end
         end

         S_FETCH: begin
            presc_d = '0;
            if (fetch_dur != 6'd0) begin
               state_d = S_PLAY;
               div_d   = step_data[9:0];
               cnt_d   = fetch_dur;
            end else if (loop && (idx_q != '0)) begin
               // Refetch step 0; a marker at step 0 itself ends the run instead.
               idx_d = '0;
            end else begin
               state_d = S_DONE;
            end
         end

         S_PLAY, S_GAP: begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
               cnt_d = cnt_q - 6'd1;
            end
            if (last_tick) begin
               presc_d = '0;
               if ((state_q == S_PLAY) && HAS_GAP) begin
                  state_d = S_GAP;
                  cnt_d   = GAP_CNT;
               end else if (!seq_end) begin
                  state_d = S_FETCH;
                  idx_d   = idx_q + 1'b1;
               end else if (loop) begin
                  // Running off the table end behaves like a marker.
                  state_d = S_FETCH;
                  idx_d   = '0;
               end else begin
                  state_d = S_DONE;
               end
            end
         end

         S_DONE: state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase

      if (stop && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         idx_d   = idx_q;
         div_d   = div_q;
         presc_d = presc_q;
         cnt_d   = cnt_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         div_q   <= '0;
         presc_q <= '0;
         cnt_q   <= '0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         div_q   <= div_d;
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
         en_q    <= (state_d == S_PLAY);
         busy_q  <= (state_d != S_IDLE);
         done_q  <= (state_d == S_DONE);
      end
   end

   assign step_addr = idx_q;
   assign div       = div_q;
   assign en        = en_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

`default_nettype wire
